// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, scan counters, registered sync/blank/color
// outputs sharing one pixel of latency, and per-frame strobes for game logic.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_ce,
  output logic       frame_start,
  output logic       vblank_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]    V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0]    HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]    HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]    VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]    VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_start_q, vblank_start_d;
  logic          h_wrap, v_wrap, visible, hs_raw, vs_raw;

  // pixel_ce is a one-Clk enable: every register below that advances the raster
  // or the DAC outputs updates only on an edge where it is high, and holds otherwise.
  assign pixel_ce = (div_q == DIV_LAST);
  assign h_wrap   = (hcount_q == H_LAST);
  assign v_wrap   = (vcount_q == V_LAST);
  assign visible  = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  assign hs_raw   = !((hcount_q >= HS_START) && (hcount_q <= HS_END));
  assign vs_raw   = !((vcount_q >= VS_START) && (vcount_q <= VS_END));

  always_comb begin
    div_d          = pixel_ce ? '0 : div_q + 1'b1;
    hcount_d       = hcount_q;
    vcount_d       = vcount_q;
    hs_d           = hs_q;
    vs_d           = vs_q;
    blank_n_d      = blank_n_q;
    r_d            = r_q;
    g_d            = g_q;
    b_d            = b_q;
    frame_start_d  = pixel_ce && h_wrap && v_wrap;
    vblank_start_d = pixel_ce && h_wrap && (vcount_q == V_VIS_LAST);
    if (pixel_ce) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
      // Sample decodes and color from the same counts so all DAC outputs stay aligned.
      hs_d      = hs_raw;
      vs_d      = vs_raw;
      blank_n_d = visible;
      r_d       = visible ? Red   : 8'd0;
      g_d       = visible ? Green : 8'd0;
      b_d       = visible ? Blue  : 8'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q          <= '0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      blank_n_q      <= 1'b0;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      div_q          <= div_d;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      blank_n_q      <= blank_n_d;
      r_q            <= r_d;
      g_q            <= g_d;
      b_q            <= b_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign DrawX        = hcount_q;
  assign DrawY        = vcount_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign VGA_BLANK_N  = blank_n_q;
  assign VGA_R        = r_q;
  assign VGA_G        = g_q;
  assign VGA_B        = b_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and drives the pixel scan coordinates DrawX/DrawY consumed by the color mapper. It registers the mapper's combinational RGB result together with delayed sync and blank signals, so the DAC-facing outputs are mutually aligned. It also emits per-frame strobes that the game logic uses to update bullet, player and enemy positions during vertical blanking.

## Interface
- CLK_DIV, 2: system clocks per pixel (≥2)
- H_VISIBLE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal timing in pixels; H_TOTAL = sum = 800
- V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical timing in lines; V_TOTAL = sum = 525
- Clk  input  1  system clock, 50 MHz
- Reset  input  1  asynchronous, active-low reset
- Red, Green, Blue  input  8 each  pixel color from color mapper for current DrawX/DrawY
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- pixel_ce  output  1  one-Clk pixel enable, every CLK_DIV Clk cycles
- frame_start  output  1  one-Clk pulse, frame begins
- vblank_start  output  1  one-Clk pulse, vertical blanking begins
- VGA_HS, VGA_VS  output  1 each  sync, active-low
- VGA_BLANK_N  output  1  high = visible pixel
- VGA_R, VGA_G, VGA_B  output  8 each  registered color, zero when blanked

## Operation
- Divider: div counts 0..CLK_DIV-1, then wraps. pixel_ce = (div == CLK_DIV-1), decoded combinationally from the registered div.
- Counters: on every Clk edge with pixel_ce=1, hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments. When vcount is at V_TOTAL-1 at that edge, vcount wraps to 0. Counters hold when pixel_ce=0.
- DrawX = hcount and DrawY = vcount, driven directly from the registers with no added delay.
- Raw decodes from the current counts:
  - visible = hcount<H_VISIBLE && vcount<V_VISIBLE
  - hs_raw low for hcount in [656,751]
  - vs_raw low for vcount in [490,491]
  - Decode bounds are derived from the parameters.
- Output stage: on each pixel_ce edge, register the following:
  - VGA_HS<=hs_raw, VGA_VS<=vs_raw, VGA_BLANK_N<=visible
  - VGA_R/G/B <= visible ? Red/Green/Blue : 0
  - Outputs hold between pixel_ce edges.
- Strobes (registered, high for exactly one Clk):
  - frame_start: asserted in the cycle after the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - vblank_start: asserted in the cycle after the counters move to (0, V_VISIBLE).
- All arithmetic is unsigned 10-bit. Counts never exceed H_TOTAL-1 or V_TOTAL-1.
- Red/Green/Blue must be valid combinationally within one pixel period of a DrawX/DrawY change.

## Timing
- Reset asserted, asynchronously and at any time including mid-frame:
  - div=0, hcount=0, vcount=0, so DrawX=DrawY=0
  - pixel_ce=0, frame_start=0, vblank_start=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0
- First pixel_ce after reset deassertion: Clk cycle CLK_DIV-1, counting the first rising edge with Reset high as cycle 0.
- No frame_start is issued at reset release. The first frame_start follows the first full wrap.
- Latency: VGA_* reflect the DrawX/DrawY/RGB that were current one pixel period (CLK_DIV Clk) earlier. Sync, blank and color share this latency exactly.
- Line period = H_TOTAL*CLK_DIV = 1600 Clk. Frame period = 525 lines = 840000 Clk.
- HS low width = 96 pixel periods. VS low width = 2 lines.
- Corner cases:
  - Simultaneous horizontal and vertical wrap at (799,524) is a single edge giving (0,0).
  - vblank_start and frame_start never coincide.
  - Color inputs are ignored whenever visible=0.

## Test plan
- Reset release, count Clk: pixel_ce first high at cycle 1, then every 2 cycles. DrawX goes 0→1 on the edge after the first pixel_ce. All outputs hold reset values until then.
- Run one line: DrawX sequence 0..799 then 0, DrawY increments once. VGA_HS low for exactly 192 Clk, starting one pixel after DrawX reaches 656.
- Run one full frame: VGA_VS low for exactly 3200 Clk. frame_start pulses once every 840000 Clk. vblank_start pulses once per frame, at (0,480).
- Drive Red/Green/Blue=FF/80/01 constantly: VGA_R/G/B=FF/80/01 only while VGA_BLANK_N=1. Values are zero at DrawX≥640 or DrawY≥480, delayed one pixel.
- Drive Red=DrawX[7:0]: VGA_R equals the previous pixel's DrawX[7:0] at each pixel_ce, confirming one-pixel alignment with VGA_BLANK_N.
- Assert Reset at DrawX=300, DrawY=200 for 3 Clk: all outputs go to reset values immediately, without waiting for a Clk edge. Counting restarts from (0,0) after release.
